rgb_pattern_encoder: RTL
========================

Name: rgb_pattern_encoder

Overview:
- Inverse of the board's RGB colour-code decoder. Turns a 6-bit two-LED RGB pattern from slide switches or PL logic back into the 3-bit colour code.
- Filters the input for stability and checks that the pattern is legal.
- Delivers each newly settled code once, on a valid/ready handshake, to downstream logic such as the PS-facing register or a code FIFO.

Parameters:
- STABLE_CYCLES, default 1000: consecutive unchanged cycles the synchronised pattern needs before it is accepted. Legal range 1 to 2^CNT_W-1.
- CNT_W, default 10: width of the stability counter.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  synchronous reset, active-high.
- pat_in  input  6  requested pattern {LED1 RGB[5:3], LED0 RGB[2:0]}; asynchronous to clk.
- code_out  output  3  encoded colour code.
- code_valid  output  1  code_out holds an undelivered code.
- code_ready  input  1  consumer accepts code_out this cycle.
- err  output  1  last settled pattern was illegal.

Behaviour:
- Reset, sampled on the clk edge: code_out=3'b111, code_valid=0, err=0, sync flops=0, prev=0, cnt=0, pending empty, last-accepted cleared. This reset aborts any handshake in flight.
- Synchroniser: two flops, pat_in -> s1 -> s2.
- Stability filter, evaluated on each edge:
  - If s2 != prev: prev<=s2, cnt<=0.
  - Else if cnt < STABLE_CYCLES: cnt<=cnt+1. The counter saturates at STABLE_CYCLES.
  - A settle event fires on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, once per settled pattern.
- Latency: code_valid rises after the (STABLE_CYCLES+3)th edge, counting from the first edge that samples the new pat_in.
- Encoding. A pattern is legal only if both halves are equal. Legal mapping, pattern -> code:
  - 100100->000
  - 101101->001
  - 110110->010
  - 010010->011
  - 011011->100
  - 001001->101
  - 111111->110
  - 000000->111
- Any other pattern, including equal halves 001 or 010 with unequal halves elsewhere, is illegal.
- Settle event handling:
  - Illegal pattern: err<=1, last-accepted cleared, no transfer.
  - Legal pattern equal to last-accepted: ignored, no transfer, err unchanged.
  - Legal new pattern: err<=0, last-accepted<=pattern. The code goes to the output stage if it is free; otherwise it goes to the pending slot.
- Output FSM has two states:
  - IDLE: code_valid=0. code_out keeps its last value.
  - SEND: code_valid=1, code_out stable.
  - Transitions: IDLE->SEND on a new code. SEND->IDLE on code_valid&&code_ready if the pending slot is empty. If pending is full, the pending code loads into code_out on the same edge and the FSM stays in SEND, so a back-to-back transfer runs with no bubble.
- Pending slot is one entry deep. A second new code arriving while it is full overwrites it; the latest code wins.
- A settle event and a handshake on the same edge: the handshake completes first, and the new code goes straight into code_out with code_valid held at 1.
- code_out and code_valid must never change while code_valid=1 && code_ready=0.

Optional Feature:
- Macro: RGB_ENC_COUNT_EN.
- Defined: adds output port xfer_cnt, 8 bits. It increments on every completed handshake, wraps 255->0, and resets to 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- STABLE_CYCLES=4. After reset, drive pat_in=6'b110110 with code_ready=1 -> code_valid rises after edge 7, code_out=3'b010, one-cycle pulse, err=0.
- Drive 6'b110110, then a 3-cycle glitch to 6'b000000, then back -> no code_valid, code_out stays 3'b010.
- Drive 6'b100101 (unequal halves) -> err=1 after edge 7, no code_valid. Then drive 6'b110110 -> code_out=3'b010 valid again, err=0.
- Hold code_ready=0. Settle 6'b101101, then 6'b011011, then 6'b001001. Then raise code_ready -> two transfers, 3'b001 then 3'b101 on consecutive cycles; 3'b100 is dropped by the overwrite.
- Assert rst for 1 cycle while code_valid=1 -> next cycle code_valid=0, code_out=3'b111, err=0. The same pattern re-settles and is sent again.
- With RGB_ENC_COUNT_EN defined, complete 257 transfers by alternating patterns -> xfer_cnt=1.

Source files
------------

// File: rtl/rgb_pattern_encoder.sv
// rgb_pattern_encoder
//   Turns a 6-bit two-LED RGB pattern back into the 3-bit colour code.
//   The pattern is synchronised and must stay unchanged for STABLE_CYCLES
//   cycles before it is accepted. Each newly settled legal code is then
//   offered once on a valid/ready handshake. A one-entry pending slot
//   holds a code while the output is busy; the newest code overwrites it.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active high
//   pat_in      {LED1 RGB, LED0 RGB}, asynchronous to clk
//   code_out    encoded colour code
//   code_valid  code_out holds an undelivered code
//   code_ready  consumer accepts code_out this cycle
//   err         last settled pattern was illegal
//   xfer_cnt    completed handshakes, mod 256 (only with RGB_ENC_COUNT_EN)
//
// Build option
//   RGB_ENC_COUNT_EN  adds the xfer_cnt output and its counter.
//
// Output FSM
//   state | meaning
//   IDLE  | nothing to deliver, code_out holds its last value
//   SEND  | code_valid=1, code_out held until accepted
module rgb_pattern_encoder #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pat_in,
  output logic [2:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       err
`ifdef RGB_ENC_COUNT_EN
  ,
  output logic [7:0] xfer_cnt
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_CYCLES);

  logic [5:0]       s1, s2, prev;
  logic [CNT_W-1:0] cnt;
  logic             settle;
  logic             legal;
  logic [2:0]       enc;
  logic             last_vld;
  logic [5:0]       last_pat;
  logic             new_code;
  logic             hs;

  state_t     state, state_nx;
  logic [2:0] code_nx;
  logic       pend_vld, pend_vld_nx;
  logic [2:0] pend, pend_nx;

  function automatic logic [2:0] enc_half(input logic [2:0] h);
    logic [2:0] c;
    case (h)
      3'b100:  c = 3'b000;
      3'b101:  c = 3'b001;
      3'b110:  c = 3'b010;
      3'b010:  c = 3'b011;
      3'b011:  c = 3'b100;
      3'b001:  c = 3'b101;
      3'b111:  c = 3'b110;
      default: c = 3'b111;
    endcase
    return c;
  endfunction

  // Fires on the edge where cnt steps from STABLE_CYCLES-1 to STABLE_CYCLES,
  // which happens only once because the counter saturates afterwards.
  assign settle   = (s2 == prev) && (cnt == STABLE_L - 1'b1);
  assign legal    = (s2[5:3] == s2[2:0]);
  assign enc      = enc_half(s2[2:0]);
  assign new_code = settle && legal && !(last_vld && (last_pat == s2));
  assign code_valid = (state == SEND);
  assign hs       = code_valid && code_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      last_vld <= 1'b0;
      last_pat <= '0;
    end else begin
      s1 <= pat_in;
      s2 <= s1;
      if (s2 != prev) begin
        prev <= s2;
        cnt  <= '0;
      end else if (cnt < STABLE_L) begin
        cnt <= cnt + 1'b1;
      end
      if (settle) begin
        if (!legal) begin
          err      <= 1'b1;
          last_vld <= 1'b0;
        end else if (new_code) begin
          err      <= 1'b0;
          last_vld <= 1'b1;
          last_pat <= s2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_out <= 3'b111;
      pend_vld <= 1'b0;
      pend     <= '0;
    end else begin
      state    <= state_nx;
      code_out <= code_nx;
      pend_vld <= pend_vld_nx;
      pend     <= pend_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    code_nx     = code_out;
    pend_vld_nx = pend_vld;
    pend_nx     = pend;
    case (state)
      IDLE: begin
        if (new_code) begin
          state_nx = SEND;
          code_nx  = enc;
        end
      end
      SEND: begin
        if (hs) begin
          if (pend_vld) begin
            // Pending code is older, so it goes out first; a code settling
            // on this same edge takes its place in the slot.
            code_nx = pend;
            if (new_code) pend_nx = enc;
            else          pend_vld_nx = 1'b0;
          end else if (new_code) begin
            code_nx = enc;
          end else begin
            state_nx = IDLE;
          end
        end else if (new_code) begin
          pend_nx     = enc;
          pend_vld_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef RGB_ENC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)     xfer_cnt <= '0;
    else if (hs) xfer_cnt <= xfer_cnt + 8'd1;
  end
`endif

endmodule
